// File: rtl/operand_select_stage_if.sv
// Handshake/bus bundle for operand_select_stage: upstream request side plus downstream ALU side.
// slave = the stage itself, master = whoever drives requests and consumes operands.
interface operand_select_stage_if #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int PC_W   = 8
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        imm_ctl;
  logic [DATA_W-1:0] reg_data;
  logic [IMM_W-1:0]  immediate;
  logic [PC_W-1:0]   pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_to_alu;
  logic [1:0]        out_sel;

  modport slave (
    input  flush, in_valid, imm_ctl, reg_data, immediate, pc, out_ready,
    output in_ready, out_valid, data_to_alu, out_sel
  );

  modport master (
    output flush, in_valid, imm_ctl, reg_data, immediate, pc, out_ready,
    input  in_ready, out_valid, data_to_alu, out_sel
  );
endinterface

// File: rtl/operand_select_stage.sv
// Registered ALU operand-B selector with valid/ready handshake and a 2-entry (head + skid) buffer.
// Optional macro OPSEL_SIGN_EXT_EN makes imm_ctl=3 select the sign-extended immediate.
module operand_select_stage #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int PC_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  operand_select_stage_if.slave   bus,
  output logic [1:0]              o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready/out_valid come straight from registers, so no ready->ready combinational path exists.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_head_data;
  logic [1:0]        r_head_sel;
  logic [DATA_W-1:0] r_skid_data;
  logic [1:0]        r_skid_sel;

  logic [PC_W-1:0]   w_pc_inc;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_accept;
  logic              w_consume;

  assign w_pc_inc  = bus.pc + PC_W'(1);
  assign w_accept  = bus.in_valid & r_in_ready & ~bus.flush;
  assign w_consume = r_out_valid & bus.out_ready;

  always_comb begin
    w_sel_data = bus.reg_data;
    case (bus.imm_ctl)
      2'd1:    w_sel_data = DATA_W'(bus.immediate);
      2'd2:    w_sel_data = DATA_W'(w_pc_inc);
`ifdef OPSEL_SIGN_EXT_EN
      2'd3:    w_sel_data = DATA_W'($signed(bus.immediate));
`else
      2'd3:    w_sel_data = bus.reg_data;
`endif
      default: w_sel_data = bus.reg_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head_data <= '0;
      r_head_sel  <= '0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
    end else if (bus.flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_head_data <= w_sel_data;
            r_head_sel  <= bus.imm_ctl;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            r_head_data <= w_sel_data;
            r_head_sel  <= bus.imm_ctl;
          end else if (w_accept) begin
            r_skid_data <= w_sel_data;
            r_skid_sel  <= bus.imm_ctl;
            r_state     <= ST_TWO;
            r_in_ready  <= 1'b0;
          end else if (w_consume) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_TWO: begin
          // Full: only the head can leave; the skid entry moves up behind it.
          if (w_consume) begin
            r_head_data <= r_skid_data;
            r_head_sel  <= r_skid_sel;
            r_state     <= ST_ONE;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.data_to_alu = r_head_data;
  assign bus.out_sel     = r_head_sel;
  assign o_dbg_state     = r_state;

endmodule
